// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with a one-byte holding register and rd/rdy handshake.
// Define UART_RX_PARITY_EN to expect an even parity bit between the data and the stop bit.
module uart_rx #(
   parameter int OS_DIV = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rd,
   output logic [7:0] dout,
   output logic       rdy,
   output logic       rts,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int DW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(OS_DIV - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state;
   logic            rxd_meta;
   logic            rxd_sync;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [3:0]      os_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            load_pend;
`ifdef UART_RX_PARITY_EN
   logic            par_bit;
`endif

   // Idle-high reset value keeps a reset release from looking like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   // Frame sequencing plus the holding register; a good byte is handed over one cycle after the stop sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         os_cnt     <= 4'd0;
         bit_idx    <= 3'd0;
         shift      <= 8'h00;
         load_pend  <= 1'b0;
         dout       <= 8'h00;
         rdy        <= 1'b0;
         rts        <= 1'b1;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         load_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (tick) os_cnt <= os_cnt + 4'd1;

         case (state)
            IDLE: begin
               if (!rxd_sync) begin
                  state   <= START;
                  os_cnt  <= 4'd0;
                  bit_idx <= 3'd0;
               end
            end
            START: begin
               if (tick && os_cnt == 4'd7) begin
                  os_cnt <= 4'd0;
                  state  <= rxd_sync ? IDLE : DATA;
               end
            end
            DATA: begin
               if (tick && os_cnt == 4'd15) begin
                  shift   <= {rxd_sync, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     os_cnt <= 4'd0;
`ifdef UART_RX_PARITY_EN
                     state  <= PARITY;
`else
                     state  <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick && os_cnt == 4'd15) begin
                  par_bit <= rxd_sync;
                  os_cnt  <= 4'd0;
                  state   <= STOP;
               end
            end
`endif
            STOP: begin
               // Leave at mid-stop so a start bit immediately following is not missed.
               if (tick && os_cnt == 4'd15) begin
                  os_cnt <= 4'd0;
                  state  <= IDLE;
                  if (!rxd_sync) begin
                     frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (^{shift, par_bit}) begin
                     parity_err <= 1'b1;
`endif
                  end else begin
                     load_pend <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (load_pend) begin
            if (!rdy || rd) begin
               dout <= shift;
               rdy  <= 1'b1;
               rts  <= 1'b0;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rd && rdy) begin
            rdy <= 1'b0;
            rts <= 1'b1;
         end
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int OS_DIV   = 4;
   localparam int BIT_CLKS = 16 * OS_DIV;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic       rd  = 1'b0;
   logic [7:0] dout;
   logic       rdy;
   logic       rts;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int tests_run    = 0;
   int tests_failed = 0;
   int fe_cycles = 0, ov_cycles = 0, pe_cycles = 0;
   int exp_fe = 0, exp_ov = 0, exp_pe = 0;
   logic [7:0] exp_dout = 8'h00;
   logic       exp_rdy  = 1'b0;

   uart_rx #(.OS_DIV(OS_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .rd         (rd),
      .dout       (dout),
      .rdy        (rdy),
      .rts        (rts),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   // Each high cycle of a pulse output is counted, so a one-cycle pulse per event keeps counts equal to events.
   always @(negedge clk) begin
      if (frame_err === 1'b1)  fe_cycles++;
      if (overrun === 1'b1)    ov_cycles++;
      if (parity_err === 1'b1) pe_cycles++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".dout"}, 32'(dout), 32'(exp_dout));
      checkOutput({tag, ".rdy"}, 32'(rdy), 32'(exp_rdy));
      checkOutput({tag, ".rts"}, 32'(rts), 32'(!exp_rdy));
      checkOutput({tag, ".frame_err_cycles"}, fe_cycles, exp_fe);
      checkOutput({tag, ".overrun_cycles"}, ov_cycles, exp_ov);
      checkOutput({tag, ".parity_err_cycles"}, pe_cycles, exp_pe);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".dout"}, 32'(dout), 32'h00);
      checkOutput({tag, ".rdy"}, 32'(rdy), 32'd0);
      checkOutput({tag, ".rts"}, 32'(rts), 32'd1);
      checkOutput({tag, ".pulses"}, 32'({frame_err, overrun, parity_err}), 32'd0);
   endtask

   task automatic applyReset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkResetValues({tag, ".immediate"});
      repeat (3) @(negedge clk);
      checkResetValues({tag, ".held"});
      rst = 1'b1;
      exp_dout = 8'h00;
      exp_rdy  = 1'b0;
      @(negedge clk);
   endtask

   task automatic sendBit(input logic b);
      rxd = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   // A bad stop bit is held low only past its middle so the DUT's re-armed start check sees a false start.
   task automatic applyStimulus(input logic [7:0] data, input bit stop_ok, input bit par_ok);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(data[i]);
      if (PAR_EN) sendBit(par_ok ? ^data : ~^data);
      if (stop_ok) begin
         sendBit(1'b1);
      end else begin
         rxd = 1'b0;
         repeat (40) @(negedge clk);
         rxd = 1'b1;
         repeat (BIT_CLKS) @(negedge clk);
      end
      if (!stop_ok)              exp_fe++;
      else if (PAR_EN && !par_ok) exp_pe++;
      else if (exp_rdy)           exp_ov++;
      else begin
         exp_dout = data;
         exp_rdy  = 1'b1;
      end
   endtask

   task automatic pulseRead();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      exp_rdy = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      bit         s_ok;
      bit         p_ok;

      applyReset("reset0");
      repeat (20) @(negedge clk);

      applyStimulus(8'hA5, 1'b1, 1'b1);
      checkState("a5");
      pulseRead();
      checkState("a5_read");

      applyReset("reset1");
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      rxd = 1'b1;
      repeat (200) @(negedge clk);
      checkState("false_start");

      applyStimulus(8'h3C, 1'b0, 1'b1);
      checkState("frame_err");

      applyStimulus(8'h11, 1'b1, 1'b1);
      applyStimulus(8'h22, 1'b1, 1'b1);
      checkState("back_to_back");
      pulseRead();
      checkState("b2b_read");

      applyStimulus(8'h77, 1'b1, 1'b1);
      checkState("pre_reset");
      sendBit(1'b0);
      for (int i = 0; i < 3; i++) sendBit(1'b1);
      applyReset("mid_frame");
      repeat (6 * BIT_CLKS) @(negedge clk);
      checkState("abandoned");
      applyStimulus(8'h5A, 1'b1, 1'b1);
      checkState("after_reset");
      pulseRead();

`ifdef UART_RX_PARITY_EN
      applyStimulus(8'h01, 1'b1, 1'b0);
      checkState("parity_bad");
      applyStimulus(8'h01, 1'b1, 1'b1);
      checkState("parity_good");
      pulseRead();
`endif

      for (int n = 0; n < 16; n++) begin
         d    = 8'($urandom);
         s_ok = ($urandom_range(0, 4) != 0);
         p_ok = ($urandom_range(0, 3) != 0);
         applyStimulus(d, s_ok, p_ok);
         repeat ($urandom_range(0, 50)) @(negedge clk);
         if ($urandom_range(0, 1) == 1) pulseRead();
         checkState($sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
